uart_tx_mmio: RTL

//  Memory-mapped UART transmitter between the RISC-V core data bus and the serial TX pin of top.
//  - Core stores bytes into an internal TX FIFO.
//  - A baud-rate divider and a frame FSM serialise each byte as 8N1, LSB first.
//  - Status and baud divisor are readable and writable by firmware.

---
 rtl/uart_tx_mmio.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bus-written TX FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned BAUD_DIV_RST = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        tx_irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
`ifdef UART_TX_PARITY_EN
  localparam logic ParEn = 1'b1;
`else
  localparam logic ParEn = 1'b0;
`endif

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic [15:0]   baud_div_q, baud_div_d;
  logic          ovf_q, ovf_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;

  logic       empty, full, push, pop, wr_data, bit_end;
  logic [7:0] head;
  logic       unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign wr_data = we && (addr == 4'h0);
  // A pop in the same cycle frees the slot the push lands in.
  assign push    = wr_data && (!full || pop);
  assign bit_end = (baud_cnt_q == 16'd0);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_d      = par_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    tx_d       = tx_q;
    pop        = 1'b0;

    if (state_q != StIdle && !bit_end) baud_cnt_d = baud_cnt_q - 16'd1;

    unique case (state_q)
      StIdle: begin
        if (!empty) pop = 1'b1;
      end
      StStart: begin
        if (bit_end) begin
          state_d    = StData;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = 3'd0;
          baud_cnt_d = baud_div_q - 16'd1;
        end
      end
      StData: begin
        if (bit_end) begin
          baud_cnt_d = baud_div_q - 16'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = StParity;
            tx_d    = par_q;
`else
            state_d = StStop;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d    = StStop;
          tx_d       = 1'b1;
          baud_cnt_d = baud_div_q - 16'd1;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Popping always starts a frame on the following cycle.
    if (pop) begin
      state_d    = StStart;
      shift_d    = head;
      par_d      = ^head;
      tx_d       = 1'b0;
      baud_cnt_d = baud_div_q - 16'd1;
    end
  end

  always_comb begin
    wptr_d     = wptr_q + (push ? PW'(1) : PW'(0));
    rptr_d     = rptr_q + (pop ? PW'(1) : PW'(0));
    baud_div_d = baud_div_q;
    ovf_d      = ovf_q;
    if (we && addr == 4'h8) baud_div_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    if (we && addr == 4'h4 && wdata[3]) ovf_d = 1'b0;
    if (wr_data && !push) ovf_d = 1'b1;
    irq_d = empty && (state_q == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      baud_div_q <= 16'(BAUD_DIV_RST);
      ovf_q      <= 1'b0;
      tx_q       <= 1'b1;
      irq_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      baud_div_q <= baud_div_d;
      ovf_q      <= ovf_d;
      tx_q       <= tx_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata[7:0];
  end

  always_comb begin
    rdata = '0;
    if (re) begin
      case (addr)
        4'h4:    rdata = {27'd0, ParEn, ovf_q, empty, full, state_q != StIdle};
        4'h8:    rdata = {16'd0, baud_div_q};
        default: rdata = '0;
      endcase
    end
  end

  assign tx     = tx_q;
  assign tx_irq = irq_q;

endmodule
